// File: rtl/sar_search_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_search_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Comparator flags packed as {eq, gt, lt}.
    localparam logic [2:0] FLAG_EQ = 3'b100;
    localparam logic [2:0] FLAG_GT = 3'b010;
    localparam logic [2:0] FLAG_LT = 3'b001;

    function automatic logic is_one_hot(input logic [2:0] flags);
        return (flags == FLAG_EQ) || (flags == FLAG_GT) || (flags == FLAG_LT);
    endfunction

endpackage

// File: rtl/sar_search_if.sv
// Search bus: start/result handshake towards control plus the comparator operand and flags.
interface sar_search_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [WIDTH-1:0] probe;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;

    modport master (
        output start, eq, gt, lt,
        input  probe, busy, done, result, found, err
    );

    modport slave (
        input  start, eq, gt, lt,
        output probe, busy, done, result, found, err
    );
endinterface

// File: rtl/sar_settle_counter.sv
// Settle timer: counts 0..SETTLE-1 while enabled and strobes sample on the last count.
module sar_settle_counter #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic sample
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    logic [CW-1:0] count;

    assign sample = enable && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end
endmodule

// File: rtl/sar_search.sv
// MSB-first successive-approximation search driving operand B of an external comparator.
// Define SAR_EARLY_EXIT_EN to end the search on the first eq sample.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    sar_search_if.slave bus
);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] PROBE = ST_PROBE;
    localparam logic [1:0] DONE  = ST_DONE;
    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] probe_q, result_q, mask, probe_upd;
    logic             busy_q, done_q, found_q, err_q;
    logic             sample;
    logic [2:0]       flags;

    assign flags      = {bus.eq, bus.gt, bus.lt};
    assign mask       = WIDTH'(1) << k;
    // Only a lt verdict drops the trial bit; gt and eq both keep it.
    assign probe_upd  = (flags == FLAG_LT) ? (probe_q & ~mask) : probe_q;

    assign bus.probe  = probe_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.found  = found_q;
    assign bus.err    = err_q;

    sar_settle_counter #(.SETTLE(SETTLE)) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != PROBE),
        .enable (state == PROBE),
        .sample (sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= '0;
            probe_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state   <= PROBE;
                        probe_q <= MSB;
                        k       <= KW'(WIDTH - 1);
                        found_q <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                PROBE: begin
                    if (sample) begin
                        if (!is_one_hot(flags)) begin
                            err_q    <= 1'b1;
                            found_q  <= 1'b0;
                            result_q <= probe_q;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            if (flags == FLAG_EQ) found_q <= 1'b1;
`ifdef SAR_EARLY_EXIT_EN
                            if (flags == FLAG_EQ) begin
                                result_q <= probe_q;
                                done_q   <= 1'b1;
                                state    <= DONE;
                            end else
`endif
                            if (k == '0) begin
                                result_q <= probe_upd;
                                done_q   <= 1'b1;
                                state    <= DONE;
                            end else begin
                                // Resolve bit k and trial-set bit k-1 in the same edge.
                                probe_q <= probe_upd | (mask >> 1);
                                k       <= k - KW'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: directed and random searches against an arithmetic model.
module tb_sar_search;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] probe;
        logic         busy;
        logic         done;
        logic [W-1:0] result;
        logic         found;
        logic         err;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    int unsigned tgt_a = 0, tgt_b = 0;
    int          mode_a = 0, mode_b = 0;   // 0: honest comparator, 1: no flags, 2: all flags
    logic        scr_a = 1'b0, scr_b = 1'b0;

    always #5 clk = ~clk;

    sar_search_if #(.WIDTH(W)) if_a ();
    sar_search_if #(.WIDTH(W)) if_b ();

    function automatic logic [2:0] cmp_flags(input int unsigned t, input logic [W-1:0] p,
                                             input int mode, input logic scr);
        if (scr || mode == 1) return 3'b000;
        if (mode == 2) return 3'b111;
        return {t == int'(p), t > int'(p), t < int'(p)};
    endfunction

    assign {if_a.eq, if_a.gt, if_a.lt} = cmp_flags(tgt_a, if_a.probe, mode_a, scr_a);
    assign {if_b.eq, if_b.gt, if_b.lt} = cmp_flags(tgt_b, if_b.probe, mode_b, scr_b);

    sar_search #(.WIDTH(W), .SETTLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    sar_search #(.WIDTH(W), .SETTLE(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic snap_t snap(input int sel);
        if (sel == 0) return '{if_a.probe, if_a.busy, if_a.done, if_a.result, if_a.found, if_a.err};
        return '{if_b.probe, if_b.busy, if_b.done, if_b.result, if_b.found, if_b.err};
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) if_a.start = v; else if_b.start = v;
    endtask

    task automatic set_scr(input int sel, input logic v);
        if (sel == 0) scr_a = v; else scr_b = v;
    endtask

    // Reference: binary search over the value range, one trial value per step.
    task automatic model(input int unsigned target, input int mode, output int unsigned probes[$],
                         output int steps, output bit found, output bit err,
                         output int unsigned res);
        int unsigned value = 0;
        probes.delete();
        found = 0;
        err   = 0;
        if (mode != 0) begin
            probes.push_back(1 << (W - 1));
            err = 1;
            res = probes[0];
        end else begin
            for (int b = W - 1; b >= 0; b--) begin
                int unsigned p = value + (1 << b);
                probes.push_back(p);
                if (p == target) begin
                    found = 1;
`ifdef SAR_EARLY_EXIT_EN
                    break;
`endif
                end
                if (target >= p) value = p;
            end
            res = target;
        end
        steps = probes.size();
    endtask

    task automatic run_search(input int sel, input int settle, input int unsigned target,
                              input int mode, input bit noisy);
        int unsigned probes[$];
        int          steps, c;
        bit          exp_found, exp_err;
        int unsigned exp_res;
        snap_t       o;
        model(target, mode, probes, steps, exp_found, exp_err, exp_res);
        @(negedge clk);
        if (sel == 0) begin tgt_a = target; mode_a = mode; end
        else begin tgt_b = target; mode_b = mode; end
        set_scr(sel, 1'b0);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        c = 0;
        o = snap(sel);
        while (c < 400) begin
            o = snap(sel);
            if (o.done) break;
            check("busy_during", o.busy, 1);
            if (c / settle < probes.size()) check("probe", o.probe, probes[c / settle]);
            if (noisy) begin
                set_scr(sel, ((c + 1) % settle) != 0);
                if (c == 1) set_start(sel, 1'b1);
                if (c == 2) set_start(sel, 1'b0);
            end
            @(negedge clk);
            c++;
        end
        set_scr(sel, 1'b0);
        set_start(sel, 1'b0);
        check("latency", c, steps * settle);
        check("done_busy", o.busy, 1);
        check("result", o.result, exp_res);
        check("found", o.found, exp_found);
        check("err", o.err, exp_err);
        check("probe_hold", o.probe, probes[probes.size() - 1]);
        if (noisy) set_start(sel, 1'b1);
        @(negedge clk);
        o = snap(sel);
        check("done_pulse", o.done, 0);
        check("busy_after", o.busy, 0);
        set_start(sel, 1'b0);
    endtask

    initial begin
        snap_t o;
        rst_n = 1'b0;
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_a", snap(0), '0);
        check("reset_b", snap(1), '0);
        rst_n = 1'b1;

        run_search(0, 1, 11, 0, 0);
        run_search(0, 1, 8, 0, 0);
        run_search(0, 1, 0, 0, 0);
        run_search(0, 1, 15, 0, 0);
        run_search(0, 1, 5, 1, 0);
        run_search(0, 1, 3, 2, 0);
        run_search(1, 3, 5, 0, 1);
        run_search(1, 3, 0, 1, 1);

        // Abandon a search with reset; no done pulse may follow.
        @(negedge clk);
        tgt_a = 11; mode_a = 0;
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_mid", snap(0), '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_no_done", if_a.done, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = snap(0);
            check("post_reset_idle", {o.busy, o.done}, 2'b00);
        end
        run_search(0, 1, 6, 0, 0);

        for (int i = 0; i < 24; i++) begin
            int r = int'($urandom_range(0, 9));
            run_search(0, 1, $urandom_range(0, (1 << W) - 1), (r == 0) ? 1 : (r == 1) ? 2 : 0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            run_search(1, 3, $urandom_range(0, (1 << W) - 1), 0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
